// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between fetch, the instruction fetch queue and the decoder.
// The queue sits on the slave modport; the fetch/decode side drives master.
interface inst_fetch_queue_if #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DEPTH + 1)
);
  logic                  in_valid;
  logic [ADDR_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_instr;
  logic                  flush;
  logic                  out_ready;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_instr;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  out_valid, out_pc, out_instr, full, empty, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output out_valid, out_pc, out_instr, full, empty, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// First-word-fall-through circular queue of {pc, instruction} between fetch and decode.
// Optional zero-latency empty-queue bypass enabled by defining INST_FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic                  full, empty, push, pop;
  logic                  bypass_hit, bypass_take;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

`ifdef INST_FETCH_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming entry straight to the decoder.
  assign bypass_hit  = empty & bus.in_valid & ~bus.flush;
  assign bypass_take = bypass_hit & bus.out_ready;
`else
  assign bypass_hit  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // A bypassed entry that the decoder consumes is never written.
  assign push = bus.in_valid & ~full & ~bus.flush & ~bypass_take;
  assign pop  = ~empty & bus.out_ready & ~bus.flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (bus.flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= bus.in_pc;
      instr_mem[wr_ptr_reg] <= bus.in_instr;
    end
  end

  assign bus.out_valid = ~empty | bypass_hit;
  assign bus.out_pc    = empty && bypass_hit ? bus.in_pc    : pc_mem[rd_ptr_reg];
  assign bus.out_instr = empty && bypass_hit ? bus.in_instr : instr_mem[rd_ptr_reg];
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_reg;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a vector table for fill/full/drain plus
// hand sequences for wrap, flush, flush-while-full, async reset and bypass.
module tb_inst_fetch_queue;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        in_valid;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    int          exp_count;
  } vec_t;

  vec_t vecs [18];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic ev, input logic [31:0] epc, input int ec);
    $display("[%0t] %s: in_valid=%0b pc=%h flush=%0b ready=%0b -> valid=%0b out_pc=%h count=%0d",
             $time, tag, bus.in_valid, bus.in_pc, bus.flush, bus.out_ready,
             bus.out_valid, bus.out_pc, bus.count);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, ".count"}, 32'(bus.count), 32'(ec));
    chk({tag, ".full"},  32'(bus.full),  32'(ec == DEPTH));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(ec == 0));
    if (ev) begin
      chk({tag, ".pc"},    bus.out_pc,    epc);
      chk({tag, ".instr"}, bus.out_instr, instr_of(epc));
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic rdy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = instr_of(pc);
    bus.flush     = fl;
    bus.out_ready = rdy;
    #1;
  endtask

  initial begin
    logic ev;
    logic [31:0] epc;

    // Fill 8, 9th dropped, full+pop with refused push, drain, empty.
    for (int i = 0; i < 9; i++)
      vecs[i] = '{1'b1, 32'h100 + 32'(4*i), 1'b0, 1'b0, i != 0, 32'h100, (i > 8) ? 8 : i};
    vecs[9] = '{1'b1, 32'h124, 1'b0, 1'b1, 1'b1, 32'h100, 8};
    for (int i = 10; i < 17; i++)
      vecs[i] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h104 + 32'(4*(i-10)), 7-(i-10)};
    vecs[17] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 0};

    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_state("reset", 1'b0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].in_valid, vecs[i].in_pc, vecs[i].flush, vecs[i].out_ready);
      ev  = vecs[i].exp_valid;
      epc = vecs[i].exp_pc;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
      if (vecs[i].exp_count == 0 && vecs[i].in_valid && !vecs[i].flush) begin
        ev  = 1'b1;
        epc = vecs[i].in_pc;
      end
`endif
      check_state($sformatf("vec%0d", i), ev, epc, vecs[i].exp_count);
    end

    // Steady push+pop at count 3, pointers wrap through 7 -> 0.
    for (int k = 0; k < 3; k++) drive(1'b1, 32'h300 + 32'(4*k), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'h30C + 32'(4*k), 1'b0, 1'b1);
      check_state($sformatf("pp%0d", k), 1'b1, 32'h300 + 32'(4*k), 3);
    end

    // Flush at count 5 with concurrent push and pop.
    drive(1'b1, 32'h35C, 1'b0, 1'b0); check_state("fl_a", 1'b1, 32'h350, 3);
    drive(1'b1, 32'h360, 1'b0, 1'b0); check_state("fl_b", 1'b1, 32'h350, 4);
    drive(1'b1, 32'h3F0, 1'b1, 1'b1); check_state("fl_c", 1'b1, 32'h350, 5);
    drive(1'b0, 32'h0,   1'b0, 1'b0); check_state("fl_d", 1'b0, 32'h0, 0);
    drive(1'b1, 32'h400, 1'b0, 1'b0);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
    check_state("fl_e", 1'b1, 32'h400, 0);
`else
    check_state("fl_e", 1'b0, 32'h0, 0);
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b1); check_state("fl_f", 1'b1, 32'h400, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0); check_state("fl_g", 1'b0, 32'h0, 0);

    // Flush while full.
    for (int k = 0; k < 8; k++) drive(1'b1, 32'h500 + 32'(4*k), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); check_state("ff_a", 1'b1, 32'h500, 8);
    drive(1'b0, 32'h0, 1'b0, 1'b0); check_state("ff_b", 1'b0, 32'h0, 0);

    // Asynchronous reset in the middle of operation at count 5.
    for (int k = 0; k < 5; k++) drive(1'b1, 32'h600 + 32'(4*k), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0); check_state("rst_a", 1'b1, 32'h600, 5);
    #2 rst_n = 1'b0;
    #1 check_state("rst_b", 1'b0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty queue, push with decoder ready.
    drive(1'b1, 32'h200, 1'b0, 1'b1);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
    check_state("byp_a", 1'b1, 32'h200, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0); check_state("byp_b", 1'b0, 32'h0, 0);
`else
    check_state("byp_a", 1'b0, 32'h0, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1); check_state("byp_b", 1'b1, 32'h200, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0); check_state("byp_c", 1'b0, 32'h0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
